// File: rtl/spsram_initiator_if.sv
// Bus bundle for spsram_initiator: command stream, response stream and the SRAM port.
// The slave modport is the initiator's view; master is the client/memory environment.
interface spsram_initiator_if #(
    parameter int W = 32,
    parameter int N = 128
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic          cmd_vld;
    logic          cmd_wen;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_din;
    logic          cmd_rdy;
    logic          rsp_vld;
    logic [W-1:0]  rsp_dout;
    logic          rsp_rdy;
    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_din;
    logic [W-1:0]  mem_dout;
    logic          init_done;

    modport slave (
        input  cmd_vld, cmd_wen, cmd_addr, cmd_din, rsp_rdy, mem_dout,
        output cmd_rdy, rsp_vld, rsp_dout, mem_en, mem_wen, mem_addr, mem_din, init_done
    );

    modport master (
        output cmd_vld, cmd_wen, cmd_addr, cmd_din, rsp_rdy, mem_dout,
        input  cmd_rdy, rsp_vld, rsp_dout, mem_en, mem_wen, mem_addr, mem_din, init_done
    );
endinterface

// File: rtl/spsram_initiator.sv
// Single-port SRAM initiator: valid/ready commands drive SRAM cycles, read data returns through a
// credit-protected response FIFO. Optional power-up clear sweep enabled by SPSRAM_INITIATOR_INIT_EN.

module spsram_initiator_chk #(
    parameter int RSP_DEPTH = 3,
    parameter int CW        = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] cnt,
    input logic [CW-1:0] outst
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (cnt == CW'(RSP_DEPTH))));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (outst <= CW'(RSP_DEPTH)) && (cnt <= outst));
endmodule

module spsram_initiator #(
    parameter int           W         = 32,
    parameter int           N         = 128,
    parameter int           RSP_DEPTH = 3,
    parameter logic [W-1:0] INIT_VAL  = '0
) (
    input logic               clk,
    input logic               rst,
    spsram_initiator_if.slave bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          init_done_q, init_done_d;
`ifdef SPSRAM_INITIATOR_INIT_EN
    logic [AW-1:0] sweep_q, sweep_d;
`endif

    logic [W-1:0]  buf_q [RSP_DEPTH];
    logic [W-1:0]  buf_d [RSP_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          rd_fly_q, rd_fly_d;

    logic          run;
    logic          cmd_rdy;
    logic          cmd_fire;
    logic          rd_acc;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RSP_DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // INIT/RUN sequencing; init_done is a registered copy of "in RUN"
    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
`ifdef SPSRAM_INITIATOR_INIT_EN
        sweep_d     = sweep_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef SPSRAM_INITIATOR_INIT_EN
                if (sweep_q == AW'(N - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    sweep_d     = sweep_q + AW'(1);
                end
`else
                state_d     = ST_RUN;
                init_done_d = 1'b1;
`endif
            end
            ST_RUN: begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = ST_INIT;
                init_done_d = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_done_q <= 1'b0;
`ifdef SPSRAM_INITIATOR_INIT_EN
            sweep_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
`ifdef SPSRAM_INITIATOR_INIT_EN
            sweep_q     <= sweep_d;
`endif
        end
    end

    // Reads consume a credit that covers both the in-flight cycle and the buffer slot
    assign run      = (state_q == ST_RUN);
    assign cmd_rdy  = run & (bus.cmd_wen | (outst_q < CW'(RSP_DEPTH)));
    assign cmd_fire = bus.cmd_vld & cmd_rdy;
    assign rd_acc   = cmd_fire & ~bus.cmd_wen;
    assign push     = rd_fly_q;
    assign pop      = bus.rsp_rdy & (cnt_q != '0);

    // SRAM port: commands pass straight through; the sweep owns the port during INIT
    always_comb begin
        bus.mem_en   = cmd_fire;
        bus.mem_wen  = bus.cmd_wen;
        bus.mem_addr = bus.cmd_addr;
        bus.mem_din  = bus.cmd_din;
        if (state_q == ST_INIT) begin
            bus.mem_din  = INIT_VAL;
`ifdef SPSRAM_INITIATOR_INIT_EN
            bus.mem_en   = ~rst;
            bus.mem_wen  = 1'b1;
            bus.mem_addr = sweep_q;
`endif
        end else begin
            bus.mem_din  = bus.cmd_din;
        end
    end

    // Response FIFO and credit bookkeeping next-state
    always_comb begin
        buf_d    = buf_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rd_fly_d = rd_acc;
        if (push) begin
            buf_d[wptr_q] = bus.mem_dout;
            wptr_d        = ptr_inc(wptr_q);
        end else begin
            wptr_d        = wptr_q;
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({rd_acc, pop})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Datapath registers; reset drops in-flight reads and buffered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            outst_q  <= '0;
            rd_fly_q <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            outst_q  <= outst_d;
            rd_fly_q <= rd_fly_d;
        end
    end

    assign bus.cmd_rdy   = cmd_rdy;
    assign bus.rsp_vld   = (cnt_q != '0);
    assign bus.rsp_dout  = buf_q[rptr_q];
    assign bus.init_done = init_done_q;

    spsram_initiator_chk #(
        .RSP_DEPTH (RSP_DEPTH),
        .CW        (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .cnt   (cnt_q),
        .outst (outst_q)
    );
endmodule

// File: doc/spsram_initiator.md
Name: spsram_initiator

Overview:
- Initiator/controller that drives a single-port synchronous SRAM port (en/wen/addr/din in, dout out, 1-cycle read latency).
- Converts a valid/ready command stream (read or write) into SRAM port cycles.
- Returns read data on a valid/ready response stream, with a response buffer that absorbs the fixed SRAM latency and downstream backpressure.
- Sits between client logic (FIFOs, tables, caches) and any single-port memory instance in the library.

Parameters:
- W, 32, data word width in bits.
- N, 128, number of memory words; address width is $clog2(N).
- RSP_DEPTH, 3, response buffer entries; must be >= 1; a value >= 3 gives full read throughput.
- INIT_VAL, '0, word written to every location by the optional init sweep.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_vld  in  1  command valid.
- cmd_wen  in  1  1 = write, 0 = read.
- cmd_addr  in  $clog2(N)  command address.
- cmd_din  in  W  write data.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- rsp_vld  out  1  read response valid.
- rsp_dout  out  W  read response data.
- rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy.
- mem_en  out  1  SRAM enable.
- mem_wen  out  1  SRAM write enable.
- mem_addr  out  $clog2(N)  SRAM address.
- mem_din  out  W  SRAM write data.
- mem_dout  in  W  SRAM read data, valid the cycle after a read enable.
- init_done  out  1  controller ready for commands.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: cmd_rdy=0, rsp_vld=0, mem_en=0, mem_wen=0, init_done=0. Response buffer and outstanding counter are cleared. mem_addr, mem_din and rsp_dout are don't-care while their qualifiers are low.
- FSM states: INIT and RUN.
  - Reset enters INIT.
  - Without the optional feature, INIT lasts exactly one cycle and then moves to RUN.
  - In RUN, init_done=1 and the state is held until rst.
- Command issue:
  - mem_en = cmd_vld & cmd_rdy (combinational, same cycle).
  - mem_wen = cmd_wen, mem_addr = cmd_addr, mem_din = cmd_din, all passed straight through.
  - No command register; the SRAM samples the command on the same edge as the handshake.
- Read credit:
  - outstanding = reads in flight (issued, data not yet captured) + buffer entries.
  - cmd_rdy = RUN & (cmd_wen | outstanding < RSP_DEPTH).
  - Writes are never credit-blocked.
  - cmd_rdy has no combinational dependence on rsp_rdy.
- Read latency:
  - Read accepted in cycle t.
  - mem_dout is sampled into the buffer at the end of cycle t+1.
  - rsp_vld is asserted from cycle t+2 at the earliest.
- Response buffer: FIFO of RSP_DEPTH entries.
  - rsp_vld = not empty; rsp_dout = head entry.
  - A push and a pop in the same cycle are both honoured.
  - Overflow is impossible by construction (credit rule); assert this in simulation.
  - Pop when empty is ignored.
- Ordering: responses are returned in read-issue order.
- Write-then-read to the same address in consecutive cycles returns the new data (SRAM write completes before the next read).
- Outstanding counter:
  - +1 on each read accept, -1 on each pop.
  - Simultaneous accept and pop: the counter is unchanged.
  - Counter width is $clog2(RSP_DEPTH+1).
- Reset mid-operation: in-flight reads and buffered responses are discarded; no rsp_vld pulse after rst.
- Throughput:
  - One command per cycle when rsp_rdy is held high and RSP_DEPTH >= 3.
  - With RSP_DEPTH < 3, back-to-back reads stall periodically; this is legal.

Optional Feature:
- Macro: SPSRAM_INITIATOR_INIT_EN.
- Defined:
  - INIT sweeps addresses 0..N-1, one per cycle, with mem_en=1, mem_wen=1, mem_din=INIT_VAL.
  - cmd_rdy=0 throughout the sweep.
  - The last write occurs in cycle N after reset deassertion; init_done rises in the following cycle.
  - rst during the sweep restarts it at address 0.
- Undefined: no sweep; init_done rises in the second cycle after rst deasserts. Memory contents are X until written.

Test Plan:
- W=32, N=16, RSP_DEPTH=3, rsp_rdy=1: write 0xDEADBEEF to addr 5, then read addr 5 the next cycle -> rsp_vld 2 cycles after the read accept, rsp_dout=0xDEADBEEF.
- Reads of addr 0..7 on consecutive cycles (memory preloaded with value=addr), rsp_rdy=1 -> cmd_rdy stays 1, 8 in-order responses 0..7 on 8 consecutive cycles.
- rsp_rdy=0, issue 5 reads -> exactly 3 accepted, then cmd_rdy=0 for reads. A write to addr 2 is still accepted while blocked. Raising rsp_rdy drains 3 in order, then the remaining 2 are accepted.
- Simultaneous read accept and response pop with 2 outstanding -> outstanding stays 2, no overflow assertion, data order preserved.
- Assert rst with 2 buffered responses and 1 read in flight -> rsp_vld=0 from the next cycle, no stale response after init_done returns high.
- With SPSRAM_INITIATOR_INIT_EN, INIT_VAL=0xA5A5A5A5, N=16 -> 16 consecutive writes to addr 0..15, init_done rises in cycle 17, a read of addr 9 returns 0xA5A5A5A5. Without the macro, init_done rises in cycle 2.
